// File: rtl/serial_add_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// helpers that size the digit counter from the operand geometry.
package serial_add_pkg;

   // Two-state controller: waiting for a request, or stepping through digits
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Number of digit steps needed to cover the whole operand
   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

   // Counter must be able to hold every value 0..n
   function automatic int count_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/digit_add.sv
// Combinational DIGIT-bit adder slice. Besides sum and carry-out it reports
// the carry into its top bit, which the parent needs for signed overflow.
module digit_add #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             cmsb
);

   // DIGIT+1 bit addition; the extra top bit is the carry out of the slice
   assign {co, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};

   // The top sum bit is x ^ y ^ carry-in at that position, so the carry into
   // the top bit can be recovered without a second adder
   assign cmsb = s[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/serial_add.sv
// Digit-serial adder: sums two WIDTH-bit operands plus carry-in, DIGIT bits
// per clock, LSB first, through a single shared digit_add slice. Results are
// published only on completion, flagged by a one-cycle done pulse.
module serial_add
   import serial_add_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGIT  = 1,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N  = num_digits(WIDTH, DIGIT);
   localparam int CW = count_width(N);

   // Reject geometries where the digits would not tile the operand exactly
   generate
      if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_add: DIGIT must be >= 1 and divide WIDTH exactly");
      end
   endgenerate

   state_t                 state;
   state_t                 state_next;
   logic [WIDTH-1:0]       a_shift;
   logic [WIDTH-1:0]       b_shift;
   logic [WIDTH-1:0]       sum_shift;
   logic [WIDTH+DIGIT-1:0] sum_cat;
   logic                   carry;
   logic [CW-1:0]          count;
   logic [DIGIT-1:0]       slice_s;
   logic                   slice_co;
   logic                   slice_cmsb;
   logic                   accept;
   logic                   last_step;

   assign accept    = (state == ST_IDLE) && start;
   assign last_step = (state == ST_RUN) && (count == CW'(N - 1));
   assign busy      = (state == ST_RUN);

   // New digit bits enter at the top of the sum shift register
   assign sum_cat = {slice_s, sum_shift};

   digit_add #(
      .DIGIT(DIGIT)
   ) u_slice (
      .x    (a_shift[DIGIT-1:0]),
      .y    (b_shift[DIGIT-1:0]),
      .ci   (carry),
      .s    (slice_s),
      .co   (slice_co),
      .cmsb (slice_cmsb)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next-state logic: leave IDLE on an accepted start, return after the last digit
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start)     state_next = ST_RUN;
         ST_RUN:  if (last_step) state_next = ST_IDLE;
         default:                state_next = ST_IDLE;
      endcase
   end

   // Datapath: capture operands on start, step one digit per cycle while
   // running, and publish sum/cout/overflow only on the final step
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_shift   <= '0;
         b_shift   <= '0;
         sum_shift <= '0;
         carry     <= 1'b0;
         count     <= '0;
         done      <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_shift   <= a;
            b_shift   <= b;
            sum_shift <= '0;
            carry     <= cin;
            count     <= '0;
         end else if (state == ST_RUN) begin
            a_shift   <= a_shift >> DIGIT;
            b_shift   <= b_shift >> DIGIT;
            sum_shift <= sum_cat[WIDTH+DIGIT-1:DIGIT];
            carry     <= slice_co;
            count     <= count + 1'b1;
            if (last_step) begin
               sum      <= sum_cat[WIDTH+DIGIT-1:DIGIT];
               cout     <= slice_co;
               overflow <= (SIGNED != 0) ? (slice_cmsb ^ slice_co) : slice_co;
               done     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/serial_add.md
Name: serial_add

Overview:
- Parametrised, multi-cycle successor to the team's registered single-bit full adder.
- Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, LSB first, reusing one DIGIT-wide adder slice.
- Start/busy/done handshake.
- Provides sum, carry-out and a selectable signed or unsigned overflow flag.
- Used in area-constrained datapaths, trading latency for adder area.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).
- SIGNED, 0, overflow mode: 0 gives overflow = cout; 1 gives two's-complement overflow (carry into MSB xor carry out of MSB).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, request; sampled only when not busy.
- a, input, WIDTH, operand A; captured on the accepted start.
- b, input, WIDTH, operand B; captured on the accepted start.
- cin, input, 1, carry-in; captured on the accepted start.
- busy, output, 1, high while an operation is in progress.
- done, output, 1, one-cycle pulse when the result is valid.
- sum, output, WIDTH, result; holds until the next completion.
- cout, output, 1, carry out of the MSB.
- overflow, output, 1, overflow per SIGNED.

Behaviour:
- Reset (asynchronous, any time):
  - state = IDLE; busy = 0, done = 0, sum = 0, cout = 0, overflow = 0.
  - Internal operand shift registers, carry register and digit counter are cleared.
- N = WIDTH/DIGIT digit steps per operation.
- State machine, IDLE and RUN:
  - IDLE: when start = 1 at edge E0, latch a, b and cin (carry register = cin), set counter = 0 and busy = 1, go to RUN.
  - RUN: at each edge Ek (k = 1..N), add the low DIGIT bits of the A and B shift registers plus the carry register. Shift the DIGIT result bits into the top of the sum shift register; shift A and B right by DIGIT; update the carry register; increment the counter.
  - At edge EN (last digit):
    - sum and cout are loaded from the completed result.
    - overflow = cout when SIGNED = 0, or carry-into-MSB xor cout when SIGNED = 1.
    - done = 1 for that one cycle; busy = 0; state returns to IDLE.
- Latency: done is high in the cycle following edge EN, exactly N cycles after the start edge. DIGIT = WIDTH gives 1-cycle latency.
- The sum, cout and overflow outputs change only at completion. Partial results are not visible on sum during RUN; an internal shift register accumulates them.
- start while busy = 1 is ignored. No queuing, and the operands are not re-captured.
- Back-to-back: start = 1 during the done cycle is accepted at that edge (state is IDLE), so the next done follows N cycles later.
- Inputs a, b and cin may change freely after the accepted start edge.
- Reset during RUN aborts the operation. No done is issued and the outputs return to 0.
- Width rules:
  - Internal carry is 1 bit.
  - The slice computes DIGIT+1 bits.
  - Carry-into-MSB is taken from the slice in the final step: bit DIGIT-1 internal carry. For DIGIT = 1 this is the carry register value before the last step.

Decomposition:
- Shared package serial_add_pkg:
  - state encoding constants ST_IDLE and ST_RUN.
  - a function computing N = WIDTH/DIGIT.
  - counter width = clog2(N+1).
- One natural sub-module, digit_add: combinational DIGIT-bit adder slice.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, cmsb (carry into the slice's top bit).
  - Instantiated once in serial_add.

Test Plan:
- WIDTH=8, DIGIT=1, SIGNED=1, reset released at 25 ns: a=8'h5A, b=8'h3C, cin=0, start for 1 cycle -> busy for 8 cycles; done pulse exactly 8 cycles after start; sum=8'h96, cout=0, overflow=1.
- WIDTH=8, DIGIT=1, SIGNED=0: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=1. Rerun with SIGNED=1 -> overflow=0.
- WIDTH=8, DIGIT=4, SIGNED=1: a=8'h7F, b=8'h00, cin=1 -> done 2 cycles after start; sum=8'h80, cout=0, overflow=1.
- Start ignored while busy: start (a=1, b=2) then start (a=9, b=9) 3 cycles later -> single done; sum=8'h03. A second start asserted during the done cycle -> accepted; sum=8'h12 after 8 more cycles.
- Reset mid-operation: assert reset 4 cycles into RUN -> busy, done, sum, cout and overflow all 0 immediately, no done pulse. A new start after release gives the correct result.
- Randomised sweep (1000 ops, DIGIT in {1,2,4,8}) against a reference model a+b+cin -> sum, cout and overflow match; latency always WIDTH/DIGIT.
